m_axi_cmd: RTL
==============

# m_axi_cmd

Single-outstanding AXI initiator that turns a simple command/response interface into single-beat AXI write and read transactions. It is the master-side counterpart of `s_axi_reg`: it drives AW/W/AR and accepts B/R. It sits between control logic (sequencers, test drivers) and any AXI slave register block in the design.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles waited for `bvalid_i`/`rvalid_i` before a forced error. Used only with `M_AXI_TIMEOUT_EN`.
- `clk` in 1: system clock, all logic on the rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in 32: byte address.
- `cmd_wdata_i` in 32: write data.
- `cmd_wstrb_i` in 4: byte enables.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: transaction error.
- AW channel: `awid_o` out 4, `awaddr_o` out 32, `awvalid_o` out 1, `awready_i` in 1.
- W channel: `wid_o` out 4, `wdata_o` out 32, `wstrb_o` out 4, `wlast_o` out 1, `wvalid_o` out 1, `wready_i` in 1.
- AR channel: `arid_o` out 4, `araddr_o` out 32, `arvalid_o` out 1, `arready_i` in 1.
- R channel: `rid_i` in 4, `rdata_i` in 32, `rstrb_i` in 4 (ignored), `rlast_i` in 1, `rvalid_i` in 1, `rready_o` out 1.
- B channel: `bid_i` in 4, `bresp_i` in 2, `bvalid_i` in 1, `bready_o` out 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i`, latch addr/data/strb and go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: `awvalid_o` and `wvalid_o` are asserted together. Each is dropped independently after its own handshake, tracked by `aw_done`/`w_done`. When both are done, go to WR_RESP. AW and W completing in the same cycle is legal.
- WR_RESP: `bready_o`=1. On `bvalid_i`: err = (`bresp_i`≠OKAY) or (`bid_i`≠current id). Go to RSP.
- RD_REQ: `arvalid_o`=1 until `arready_i`, then go to RD_RESP.
- RD_RESP: `rready_o`=1. On `rvalid_i`: capture `rdata_i`; err = (`rid_i`≠id) or !`rlast_i`. Go to RSP.
- RSP: `rsp_valid_o`=1 with data and err held stable until `rsp_ready_i`, then go to IDLE.
- Transaction ID: 4-bit counter, used for both AWID/WID and ARID. It increments on leaving RSP and wraps 15→0.
- AXI rules: once a valid is asserted, it and its payload are held until the handshake. A valid never depends on the corresponding ready.
- `wlast_o` = `wvalid_o` (single beat).

## Timing
- Reset values: all `*valid_o`, `bready_o`, `rready_o`, `rsp_*` = 0. Addresses, data, `wstrb_o`, and ids = 0. `cmd_ready_o`=1. State = IDLE.
- Command accept at edge N → AW/W (or AR) valid from cycle N+1.
- Best case, write: accept → `rsp_valid_o` 3 cycles (slave ready=1, `bvalid_i` one cycle after W).
- Best case, read: accept → `rsp_valid_o` 3 cycles.
- `cmd_ready_o` is low from the accept cycle+1 until return to IDLE; only one transaction is in flight.
- Response back-to-back: with `rsp_ready_i`=1, the next command can be accepted 1 cycle after `rsp_valid_o` rises.
- Unexpected `bvalid_i`/`rvalid_i` outside WR_RESP/RD_RESP is ignored (its ready is 0).
- Reset mid-transaction: immediate return to IDLE; all valids drop asynchronously; the id counter returns to 0.

## Configuration
- `M_AXI_TIMEOUT_EN` defined: a counter runs in WR_RESP/RD_RESP. If it reaches `TIMEOUT_CYCLES` without a response, go to RSP with `rsp_err_o`=1 and `rsp_rdata_o`=0. The counter clears on state entry.
- Undefined: no counter; the block waits forever.

## Structure
- `m_axi_pkg`: state enum, `RESP_OKAY`=2'b00 / `RESP_SLVERR`=2'b10, `ID_W`=4, `ADDR_W`=32, `DATA_W`=32.
- One sub-module, `m_axi_timeout`: loadable down-counter with an expire flag, instantiated only under `M_AXI_TIMEOUT_EN`.

## Test plan
- Write 0x0000_0004, data 0xDEAD_BEEF, strb 4'hF, slave always ready, `bresp_i`=0, `bid_i`=0 → AW/W valid 1 cycle later; `rsp_valid_o` with err=0.
- Read 0x4 with `rdata_i`=0xDEAD_BEEF, `rid_i`=1, `rlast_i`=1 → `rsp_rdata_o`=0xDEAD_BEEF, err=0, `arid_o`=1.
- `awready_i` delayed 3 cycles and `wready_i` immediate → `wvalid_o` drops after 1 cycle, `awvalid_o` held stable 4 cycles, exactly one B accepted.
- `bresp_i`=2'b10 → `rsp_err_o`=1. `rid_i` mismatch on a read → `rsp_err_o`=1.
- Issue 17 commands → ids 0..15, then 0. With `rsp_ready_i` held low for 5 cycles, `rsp_*` stays stable and `cmd_ready_o`=0.
- `M_AXI_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no `bvalid_i` → `rsp_err_o`=1 after 8 cycles in WR_RESP. `areset` pulse during RD_REQ → `arvalid_o`=0, `cmd_ready_o`=1.

Source files
------------

// File: rtl/m_axi_pkg.sv
// Shared types and constants for the single-outstanding AXI command initiator.
// Holds the FSM state encoding, AXI response codes, bus widths and the
// packed record used to hold a latched command.
package m_axi_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    // Command fields captured on accept and held as the AXI payload.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } cmd_t;

endpackage

// File: rtl/m_axi_timeout.sv
// Response watchdog: loadable down-counter that flags expiry while running.
// Latency: expired is combinational from the count; load takes effect next edge.
// Backpressure: none; the counter simply holds at zero once expired.
// Ports: clk/areset, load + load_val (reload), run (count enable), expired.
module m_axi_timeout #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Only meaningful while running; a stale zero outside the wait states is masked.
    assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/m_axi_cmd.sv
// Single-outstanding AXI initiator: command/response port to one-beat AW/W/B or AR/R.
// Latency: accept -> AW/W or AR valid next cycle; best case accept -> rsp_valid 3 cycles.
// Backpressure: cmd_ready low while a transaction is in flight; rsp held until rsp_ready.
// Ports: cmd_* (request in), rsp_* (result out), AXI AW/W/B/AR/R master channels.
// Optional build macro M_AXI_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on B/R waits;
// without it the block waits for the response indefinitely.
module m_axi_cmd
    import m_axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              areset,
    // command / response side
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [STRB_W-1:0] cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    // AW channel
    output logic [ID_W-1:0]   awid_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    // W channel
    output logic [ID_W-1:0]   wid_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    // AR channel
    output logic [ID_W-1:0]   arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    // R channel
    input  logic [ID_W-1:0]   rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [STRB_W-1:0] rstrb_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    // B channel
    input  logic [ID_W-1:0]   bid_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    state_t            state_q, state_d;
    cmd_t              cmd_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              aw_done_q, w_done_q;

    logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;
    logic tmo_expired;
    logic unused_ok;

    // Valids are decoded from registered state only, so they never look at
    // their ready and drop the instant areset asserts.
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign awvalid_o   = (state_q == ST_WR_REQ) && !aw_done_q;
    assign wvalid_o    = (state_q == ST_WR_REQ) && !w_done_q;
    assign wlast_o     = wvalid_o;
    assign arvalid_o   = (state_q == ST_RD_REQ);
    assign bready_o    = (state_q == ST_WR_RESP);
    assign rready_o    = (state_q == ST_RD_RESP);
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign awid_o   = id_q;
    assign wid_o    = id_q;
    assign arid_o   = id_q;
    assign awaddr_o = cmd_q.addr;
    assign araddr_o = cmd_q.addr;
    assign wdata_o  = cmd_q.wdata;
    assign wstrb_o  = cmd_q.wstrb;

    assign accept = cmd_valid_i && cmd_ready_o;
    assign aw_hs  = awvalid_o && awready_i;
    assign w_hs   = wvalid_o && wready_i;
    assign ar_hs  = arvalid_o && arready_i;
    assign b_hs   = bvalid_i && bready_o;
    assign r_hs   = rvalid_i && rready_o;
    assign rsp_hs = rsp_valid_o && rsp_ready_i;

`ifdef M_AXI_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic tmo_load, tmo_run;

    // Reload on every entry into a response wait so each wait gets a full budget.
    assign tmo_load = (state_d != state_q) &&
                      ((state_d == ST_WR_RESP) || (state_d == ST_RD_RESP));
    assign tmo_run  = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);

    m_axi_timeout #(
        .CNT_W (TMO_W)
    ) u_timeout (
        .clk      (clk),
        .areset   (areset),
        .load     (tmo_load),
        .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
        .run      (tmo_run),
        .expired  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // R strobes carry no information for a single-beat read.
    assign unused_ok = ^{rstrb_i, (TIMEOUT_CYCLES != 0)};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) state_d = cmd_write_i ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                // AW and W may finish in either order or in the same cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bvalid_i || tmo_expired) state_d = ST_RSP;
            end
            ST_RD_REQ: begin
                if (arready_i) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rvalid_i || tmo_expired) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cmd_q     <= '0;
            id_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q.addr  <= cmd_addr_i;
                cmd_q.wdata <= cmd_wdata_i;
                cmd_q.wstrb <= cmd_wstrb_i;
                rdata_q     <= '0;
                err_q       <= 1'b0;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;

            // A real response wins over a watchdog expiry in the same cycle.
            if (b_hs) begin
                err_q <= (bresp_i != RESP_OKAY) || (bid_i != id_q);
            end else if (r_hs) begin
                rdata_q <= rdata_i;
                err_q   <= (rid_i != id_q) || !rlast_i;
            end else if (tmo_expired && (bready_o || rready_o)) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end

            // ar_hs needs no bookkeeping: the FSM leaves RD_REQ on it directly.
            if (rsp_hs) id_q <= id_q + ID_W'(1);
        end
    end

    logic unused_ar_hs;
    assign unused_ar_hs = ar_hs;

endmodule
